// File: rtl/lc3_pkg.sv
// Shared LC-3 interrupt definitions: controller state encoding, priority width
// and the default device vectors.
package lc3_pkg;

   localparam int PRIO_W = 3;

   localparam logic [7:0] VEC_KBD = 8'h80;
   localparam logic [7:0] VEC_DSP = 8'h81;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_CLEAR   = 2'd2,
      ST_HOLDOFF = 2'd3
   } int_state_e;

endpackage

// File: rtl/lc3_int_prio_arbiter.sv
// Combinational priority arbiter: a source qualifies when requesting with a
// priority strictly above the floor; highest priority wins, ties to lowest index.
module lc3_int_prio_arbiter
   import lc3_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int VEC_W   = 8,
   parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0]        req_i,
   input  logic [PRIO_W*NUM_SRC-1:0] prio_i,
   input  logic [VEC_W*NUM_SRC-1:0]  vec_i,
   input  logic [PRIO_W-1:0]         floor_i,
   output logic [NUM_SRC-1:0]        qual_o,
   output logic                      valid_o,
   output logic [IDX_W-1:0]          idx_o,
   output logic [PRIO_W-1:0]         prio_o,
   output logic [VEC_W-1:0]          vec_o
);

   logic [PRIO_W-1:0] src_prio;

   always_comb begin
      qual_o   = '0;
      valid_o  = 1'b0;
      idx_o    = '0;
      prio_o   = '0;
      vec_o    = '0;
      src_prio = '0;
      // Ascending scan with a strict compare keeps the lowest index on ties.
      for (int k = 0; k < NUM_SRC; k++) begin
         src_prio  = prio_i[PRIO_W*k +: PRIO_W];
         qual_o[k] = req_i[k] && (src_prio > floor_i);
         if (qual_o[k] && (!valid_o || (src_prio > prio_o))) begin
            valid_o = 1'b1;
            idx_o   = IDX_W'(k);
            prio_o  = src_prio;
            vec_o   = vec_i[VEC_W*k +: VEC_W];
         end
      end
   end

endmodule

// File: rtl/lc3_interrupt_controller.sv
// LC-3 interrupt controller: latches one winner for the microsequencer, clears it on
// ack, then holds off re-arbitration. Optional source mask under LC3_INT_MASK_EN.
module lc3_interrupt_controller
   import lc3_pkg::*;
#(
   parameter int NUM_SRC     = 4,
   parameter int VEC_W       = 8,
   parameter int HOLDOFF_CYC = 4
) (
   input  logic                      i_CLK,
   input  logic                      i_RST_N,
   input  logic [NUM_SRC-1:0]        i_IRQ,
   input  logic [PRIO_W*NUM_SRC-1:0] i_IRQ_PRIO,
   input  logic [VEC_W*NUM_SRC-1:0]  i_IRQ_VEC,
   input  logic [PRIO_W-1:0]         i_PSR_PRIO,
   input  logic                      i_INT_ACK,
`ifdef LC3_INT_MASK_EN
   input  logic                      i_MASK_WE,
   input  logic [NUM_SRC-1:0]        i_MASK_DATA,
`endif
   output logic                      o_INT,
   output logic [VEC_W-1:0]          o_INTV,
   output logic [PRIO_W-1:0]         o_INT_PRIO,
   output logic [NUM_SRC-1:0]        o_IRQ_CLR,
   output logic                      o_BUSY,
   output int_state_e                o_DBG_STATE
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int CNT_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

   // Handshake: o_INT stays high from latch until the cycle i_INT_ACK is sampled;
   // o_IRQ_CLR then pulses for exactly one cycle, with no ready/back-pressure.
   int_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [VEC_W-1:0]  vec_q, vec_d;
   logic [PRIO_W-1:0] prio_q, prio_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [NUM_SRC-1:0] req_en;
   logic [NUM_SRC-1:0] qual;
   logic               win_valid;
   logic [IDX_W-1:0]   win_idx;
   logic [PRIO_W-1:0]  win_prio;
   logic [VEC_W-1:0]   win_vec;
   logic               preempt;

`ifdef LC3_INT_MASK_EN
   logic [NUM_SRC-1:0] mask_q;

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         mask_q <= '1;
      end else if (i_MASK_WE) begin
         mask_q <= i_MASK_DATA;
      end
   end

   assign req_en = i_IRQ & mask_q;
`else
   assign req_en = i_IRQ;
`endif

   lc3_int_prio_arbiter #(
      .NUM_SRC (NUM_SRC),
      .VEC_W   (VEC_W),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req_i   (req_en),
      .prio_i  (i_IRQ_PRIO),
      .vec_i   (i_IRQ_VEC),
      .floor_i (i_PSR_PRIO),
      .qual_o  (qual),
      .valid_o (win_valid),
      .idx_o   (win_idx),
      .prio_o  (win_prio),
      .vec_o   (win_vec)
   );

   assign preempt = win_valid && (win_idx != idx_q) && (win_prio > prio_q);

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         vec_q   <= '0;
         prio_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         vec_q   <= vec_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      vec_d   = vec_q;
      prio_d  = prio_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               idx_d   = win_idx;
               vec_d   = win_vec;
               prio_d  = win_prio;
               state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            // Ack wins over cancel, cancel wins over preempt.
            if (i_INT_ACK) begin
               state_d = ST_CLEAR;
            end else if (!qual[idx_q]) begin
               state_d = ST_IDLE;
            end else if (preempt) begin
               idx_d  = win_idx;
               vec_d  = win_vec;
               prio_d = win_prio;
            end
         end
         ST_CLEAR: begin
            cnt_d   = CNT_W'(HOLDOFF_CYC - 1);
            state_d = ST_HOLDOFF;
         end
         ST_HOLDOFF: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_IRQ_CLR = '0;
      if (state_q == ST_CLEAR) begin
         o_IRQ_CLR[idx_q] = 1'b1;
      end
   end

   assign o_INT       = (state_q == ST_PENDING);
   assign o_BUSY      = (state_q != ST_IDLE);
   assign o_INTV      = vec_q;
   assign o_INT_PRIO  = prio_q;
   assign o_DBG_STATE = state_q;

endmodule

// File: tb/tb_lc3_interrupt_controller.sv
// Directed bench for lc3_interrupt_controller (NUM_SRC=4, VEC_W=8, HOLDOFF_CYC=4);
// mask vectors run only when LC3_INT_MASK_EN is defined.
module tb_lc3_interrupt_controller;
   import lc3_pkg::*;

   localparam int NUM_SRC     = 4;
   localparam int VEC_W       = 8;
   localparam int HOLDOFF_CYC = 4;

   logic                      clk;
   logic                      rst_n;
   logic [NUM_SRC-1:0]        irq;
   logic [PRIO_W*NUM_SRC-1:0] irq_prio;
   logic [VEC_W*NUM_SRC-1:0]  irq_vec;
   logic [PRIO_W-1:0]         psr_prio;
   logic                      int_ack;
   logic                      int_o;
   logic [VEC_W-1:0]          intv;
   logic [PRIO_W-1:0]         int_prio;
   logic [NUM_SRC-1:0]        irq_clr;
   logic                      busy;
   int_state_e                dbg_state;
`ifdef LC3_INT_MASK_EN
   logic                      mask_we;
   logic [NUM_SRC-1:0]        mask_data;
`endif

   int n_checks;
   int n_errors;

   lc3_interrupt_controller #(
      .NUM_SRC     (NUM_SRC),
      .VEC_W       (VEC_W),
      .HOLDOFF_CYC (HOLDOFF_CYC)
   ) dut (
      .i_CLK       (clk),
      .i_RST_N     (rst_n),
      .i_IRQ       (irq),
      .i_IRQ_PRIO  (irq_prio),
      .i_IRQ_VEC   (irq_vec),
      .i_PSR_PRIO  (psr_prio),
      .i_INT_ACK   (int_ack),
`ifdef LC3_INT_MASK_EN
      .i_MASK_WE   (mask_we),
      .i_MASK_DATA (mask_data),
`endif
      .o_INT       (int_o),
      .o_INTV      (intv),
      .o_INT_PRIO  (int_prio),
      .o_IRQ_CLR   (irq_clr),
      .o_BUSY      (busy),
      .o_DBG_STATE (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1ns after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int k, input logic [PRIO_W-1:0] p, input logic [VEC_W-1:0] v);
      irq_prio[PRIO_W*k +: PRIO_W] = p;
      irq_vec[VEC_W*k +: VEC_W]    = v;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (dbg_state != ST_IDLE && n < 20) begin
         tick();
         n++;
      end
      check_eq(tag, 32'(dbg_state), 32'(ST_IDLE));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      irq      = '0;
      irq_prio = '0;
      irq_vec  = '0;
      psr_prio = '0;
      int_ack  = 1'b0;
`ifdef LC3_INT_MASK_EN
      mask_we   = 1'b0;
      mask_data = '0;
`endif
      set_src(0, 3'd0, 8'h10);
      set_src(1, 3'd0, VEC_KBD);
      set_src(2, 3'd0, VEC_DSP);
      set_src(3, 3'd0, 8'h33);

      // Reset values
      tick();
      check_eq("rst_int", 32'(int_o), 32'h0);
      check_eq("rst_intv", 32'(intv), 32'h0);
      check_eq("rst_prio", 32'(int_prio), 32'h0);
      check_eq("rst_clr", 32'(irq_clr), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      tick();
      check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));

      // Ack in IDLE is ignored
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      check_eq("idle_ack_state", 32'(dbg_state), 32'(ST_IDLE));
      check_eq("idle_ack_clr", 32'(irq_clr), 32'h0);

      // Single request, ack, hold-off, re-latch of the still-asserted source
      set_src(1, 3'd4, VEC_KBD);
      irq = 4'b0010;
      tick();
      check_eq("single_int", 32'(int_o), 32'h1);
      check_eq("single_intv", 32'(intv), 32'h80);
      check_eq("single_prio", 32'(int_prio), 32'h4);
      check_eq("single_busy", 32'(busy), 32'h1);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      check_eq("clr_pulse", 32'(irq_clr), 32'h2);
      check_eq("clr_int", 32'(int_o), 32'h0);
      check_eq("clr_intv_held", 32'(intv), 32'h80);
      check_eq("clr_prio_held", 32'(int_prio), 32'h4);
      for (int i = 0; i < HOLDOFF_CYC; i++) begin
         tick();
         check_eq("hold_int", 32'(int_o), 32'h0);
         check_eq("hold_clr", 32'(irq_clr), 32'h0);
         check_eq("hold_busy", 32'(busy), 32'h1);
      end
      tick();
      check_eq("hold_end_busy", 32'(busy), 32'h0);
      check_eq("hold_end_int", 32'(int_o), 32'h0);
      tick();
      check_eq("relatch_int", 32'(int_o), 32'h1);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      irq     = '0;
      check_eq("clr_pulse2", 32'(irq_clr), 32'h2);
      wait_idle("idle_after_ack");

      // Priority filter against PSR, then cancel when PSR rises
      psr_prio = 3'd4;
      set_src(0, 3'd4, 8'h10);
      irq = 4'b0001;
      tick();
      check_eq("filter_eq_int", 32'(int_o), 32'h0);
      tick();
      check_eq("filter_eq_int2", 32'(int_o), 32'h0);
      set_src(0, 3'd5, 8'h10);
      tick();
      check_eq("filter_gt_int", 32'(int_o), 32'h1);
      check_eq("filter_gt_prio", 32'(int_prio), 32'h5);
      check_eq("filter_gt_intv", 32'(intv), 32'h10);
      psr_prio = 3'd5;
      tick();
      check_eq("psr_cancel_int", 32'(int_o), 32'h0);
      check_eq("psr_cancel_clr", 32'(irq_clr), 32'h0);
      check_eq("psr_cancel_state", 32'(dbg_state), 32'(ST_IDLE));
      irq      = '0;
      psr_prio = '0;

      // Tie goes to lowest index, then strict-higher preempt
      set_src(0, 3'd3, 8'h10);
      set_src(2, 3'd3, VEC_DSP);
      irq = 4'b0101;
      tick();
      check_eq("tie_int", 32'(int_o), 32'h1);
      check_eq("tie_intv", 32'(intv), 32'h10);
      set_src(3, 3'd6, 8'h33);
      irq = 4'b1101;
      tick();
      check_eq("preempt_int", 32'(int_o), 32'h1);
      check_eq("preempt_intv", 32'(intv), 32'h33);
      check_eq("preempt_prio", 32'(int_prio), 32'h6);

      // Latched source drops without ack: cancel, no clear pulse
      irq = 4'b0101;
      tick();
      check_eq("drop_int", 32'(int_o), 32'h0);
      check_eq("drop_clr", 32'(irq_clr), 32'h0);
      tick();
      check_eq("relatch_tie_int", 32'(int_o), 32'h1);
      check_eq("relatch_tie_intv", 32'(intv), 32'h10);

      // Drop and ack in the same cycle: ack wins
      irq     = 4'b0000;
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      check_eq("dropack_clr", 32'(irq_clr), 32'h1);
      check_eq("dropack_state", 32'(dbg_state), 32'(ST_CLEAR));
      check_eq("dropack_intv", 32'(intv), 32'h10);
      tick();
      check_eq("dropack_clr_gone", 32'(irq_clr), 32'h0);
      wait_idle("idle_after_dropack");

      // Asynchronous reset in the middle of CLEAR
      irq = 4'b0010;
      tick();
      check_eq("pre_rst_int", 32'(int_o), 32'h1);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      irq     = '0;
      check_eq("pre_rst_clr", 32'(irq_clr), 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_clr", 32'(irq_clr), 32'h0);
      check_eq("arst_busy", 32'(busy), 32'h0);
      check_eq("arst_intv", 32'(intv), 32'h0);
      check_eq("arst_prio", 32'(int_prio), 32'h0);
      check_eq("arst_int", 32'(int_o), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      check_eq("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check_eq("post_rst_clr", 32'(irq_clr), 32'h0);

`ifdef LC3_INT_MASK_EN
      // Masked source cannot qualify; re-enabling lets it latch
      mask_we   = 1'b1;
      mask_data = 4'b1101;
      tick();
      mask_we = 1'b0;
      irq     = 4'b0010;
      tick();
      check_eq("mask_off_int", 32'(int_o), 32'h0);
      tick();
      check_eq("mask_off_int2", 32'(int_o), 32'h0);
      mask_we   = 1'b1;
      mask_data = 4'b1111;
      tick();
      mask_we = 1'b0;
      tick();
      check_eq("mask_on_int", 32'(int_o), 32'h1);
      check_eq("mask_on_intv", 32'(intv), 32'h80);
      // Clearing the latched source's mask bit cancels
      mask_we   = 1'b1;
      mask_data = 4'b1101;
      tick();
      mask_we = 1'b0;
      tick();
      check_eq("mask_cancel_state", 32'(dbg_state), 32'(ST_IDLE));
      check_eq("mask_cancel_clr", 32'(irq_clr), 32'h0);
      irq = '0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
